ts_sync_detector: RTL and testbench

- Per-channel MPEG2-TS byte-stream synchroniser; one instance per input channel.
- Hunts for the 0x47 sync byte at 188-byte spacing and declares lock after repeated hits. Flywheels through isolated misses and drops lock after repeated misses.
- Its `sync` output drives one bit of the 4-bit channel sync bus feeding the channel sync selector mux.
- Also forwards the byte stream with a packet-start marker.

---
 rtl/ts_pkg.sv | 10 +
 rtl/ts_pos_counter.sv | 18 +
 rtl/ts_sync_detector.sv | 102 ++++++++++
 tb/tb_ts_sync_detector.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/ts_pkg.sv
// ts_pkg: shared MPEG2-TS constants and synchroniser state encoding.
package ts_pkg;
  localparam int TS_PKT_LEN = 188;
  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } ts_state_e;
endpackage

// File: rtl/ts_pos_counter.sv
// ts_pos_counter: byte position within a TS packet, wrapping at PKT_LEN, with clear and boundary flag.
module ts_pos_counter #(
  parameter int PKT_LEN = 188
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic is_boundary
);
  localparam logic [7:0] LAST = 8'(PKT_LEN - 1);
  logic [7:0] pos;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pos <= 8'd0;
    else if (clr) pos <= 8'd0;
    else if (en) pos <= (pos == LAST) ? 8'd0 : pos + 8'd1;
  assign is_boundary = (pos == 8'd0);
endmodule

// File: rtl/ts_sync_detector.sv
// ts_sync_detector: per-channel TS sync hunter with lock/flywheel/unlock and 1-cycle forwarded stream.
// Define TS_SYNC_ERRCNT_EN to add the saturating sync_err_cnt output.
module ts_sync_detector
  import ts_pkg::*;
#(
  parameter int         PKT_LEN    = TS_PKT_LEN,
  parameter logic [7:0] SYNC_BYTE  = TS_SYNC_BYTE,
  parameter int         LOCK_CNT   = 3,
  parameter int         UNLOCK_CNT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic [7:0] byte_out,
  output logic       valid_out,
  output logic       pkt_start,
  output logic       sync
`ifdef TS_SYNC_ERRCNT_EN
  ,output logic [15:0] sync_err_cnt
`endif
);
  localparam logic [7:0] LOCK_TH   = 8'(LOCK_CNT);
  localparam logic [7:0] UNLOCK_TH = 8'(UNLOCK_CNT);
  ts_state_e  state, state_n;
  logic [7:0] hit_cnt, hit_n, miss_cnt, miss_n;
  logic       adv, clr, pkt, bnd, match;
  assign match = (byte_in == SYNC_BYTE);
  ts_pos_counter #(.PKT_LEN(PKT_LEN)) u_pos (
    .clk(clk), .rst_n(rst_n), .en(adv), .clr(clr), .is_boundary(bnd)
  );
  always_comb begin
    state_n = state;
    hit_n = hit_cnt;
    miss_n = miss_cnt;
    adv = 1'b0;
    clr = 1'b0;
    pkt = 1'b0;
    if (byte_valid) begin
      case (state)
        HUNT: if (match) begin
          adv = 1'b1;
          hit_n = (LOCK_CNT == 1) ? 8'd0 : 8'd1;
          miss_n = 8'd0;
          pkt = (LOCK_CNT == 1);
          state_n = (LOCK_CNT == 1) ? LOCKED : VERIFY;
        end
        VERIFY: begin
          adv = 1'b1;
          if (bnd && match) begin
            hit_n = (hit_cnt + 8'd1 >= LOCK_TH) ? 8'd0 : hit_cnt + 8'd1;
            pkt = (hit_cnt + 8'd1 >= LOCK_TH);
            miss_n = 8'd0;
            state_n = (hit_cnt + 8'd1 >= LOCK_TH) ? LOCKED : VERIFY;
          end else if (bnd) begin
            clr = 1'b1;
            hit_n = 8'd0;
            state_n = HUNT;
          end
        end
        LOCKED: begin
          adv = 1'b1;
          if (bnd && match) begin
            miss_n = 8'd0;
            pkt = 1'b1;
          end else if (bnd) begin
            clr = (miss_cnt + 8'd1 >= UNLOCK_TH);
            miss_n = (miss_cnt + 8'd1 >= UNLOCK_TH) ? 8'd0 : miss_cnt + 8'd1;
            hit_n = 8'd0;
            pkt = (miss_cnt + 8'd1 < UNLOCK_TH);
            state_n = (miss_cnt + 8'd1 >= UNLOCK_TH) ? HUNT : LOCKED;
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= HUNT;
      hit_cnt <= 8'd0;
      miss_cnt <= 8'd0;
      byte_out <= 8'd0;
      valid_out <= 1'b0;
      pkt_start <= 1'b0;
      sync <= 1'b0;
    end else begin
      state <= state_n;
      hit_cnt <= hit_n;
      miss_cnt <= miss_n;
      if (byte_valid) byte_out <= byte_in;
      valid_out <= byte_valid;
      pkt_start <= pkt;
      sync <= (state_n == LOCKED);
    end
`ifdef TS_SYNC_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_err_cnt <= 16'd0;
    else if (byte_valid && state == LOCKED && bnd && !match && sync_err_cnt != 16'hFFFF)
      sync_err_cnt <= sync_err_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_ts_sync_detector.sv
// tb_ts_sync_detector: directed checks of lock, flywheel, unlock, false sync, gaps and async reset.
module tb_ts_sync_detector;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] byte_in = 8'd0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_out;
  logic       valid_out, pkt_start, sync;
`ifdef TS_SYNC_ERRCNT_EN
  logic [15:0] err_cnt;
`endif
  int n_cmp = 0, n_bad = 0, pkt_seen = 0, gap_bad = 0, sync_seen = 0;

  ts_sync_detector dut (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_out(byte_out), .valid_out(valid_out), .pkt_start(pkt_start), .sync(sync)
`ifdef TS_SYNC_ERRCNT_EN
    ,.sync_err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic v);
    @(negedge clk);
    byte_in = b;
    byte_valid = v;
    @(posedge clk);
    #1;
    if (pkt_start) pkt_seen++;
    if (!v && (valid_out || pkt_start)) gap_bad++;
    if (sync) sync_seen++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    byte_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pkt_seen = 0;
    gap_bad = 0;
    sync_seen = 0;
  endtask

  function automatic logic [7:0] ts(input int i, input int first);
    return (i >= first && (i - first) % 188 == 0) ? 8'h47 : 8'h00;
  endfunction

  initial begin
    logic [7:0] b;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sync", sync, 0);
    check("rst_pkt_start", pkt_start, 0);
    check("rst_valid_out", valid_out, 0);
    check("rst_byte_out", byte_out, 0);
`ifdef TS_SYNC_ERRCNT_EN
    check("rst_err_cnt", err_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 940; i++) begin
      send(ts(i, 0), 1'b1);
      if (i == 188) check("clean_sync_188", sync, 0);
      if (i == 375) check("clean_sync_375", sync, 0);
      if (i == 376) begin
        check("clean_sync_376", sync, 1);
        check("clean_pkt_376", pkt_start, 1);
        check("clean_byte_376", byte_out, 8'h47);
        check("clean_valid_376", valid_out, 1);
      end
      if (i == 377) check("clean_pkt_377", pkt_start, 0);
    end
    check("clean_pkt_count", pkt_seen, 3);

    do_reset();
    for (int i = 0; i < 940; i++) begin
      send(ts(i, 0), 1'b1);
      if (i == 375) check("gap_sync_375", sync, 0);
      if (i == 376) begin
        check("gap_sync_376", sync, 1);
        check("gap_pkt_376", pkt_start, 1);
      end
      send(8'h47, 1'b0);
      if (i == 1) check("gap_byte_hold", byte_out, 8'h00);
    end
    check("gap_idle_outputs", gap_bad, 0);
    check("gap_pkt_count", pkt_seen, 3);

    do_reset();
    for (int i = 0; i < 1317; i++) begin
      b = ts(i, 0);
      if (i == 564 || i == 940 || i == 1128) b = 8'h00;
      send(b, 1'b1);
      if (i == 564) begin
        check("fly_sync_564", sync, 1);
        check("fly_pkt_564", pkt_start, 1);
`ifdef TS_SYNC_ERRCNT_EN
        check("fly_err_564", err_cnt, 1);
`endif
      end
      if (i == 1128) check("fly_sync_1128", sync, 1);
      if (i == 1316) begin
        check("fly_sync_1316", sync, 1);
        check("fly_pkt_1316", pkt_start, 1);
      end
    end

    do_reset();
    for (int i = 0; i < 1505; i++) begin
      b = ts(i, 0);
      if (i == 564 || i == 752 || i == 940) b = 8'h00;
      send(b, 1'b1);
      if (i == 752) begin
        check("loss_sync_752", sync, 1);
        check("loss_pkt_752", pkt_start, 1);
      end
      if (i == 940) begin
        check("loss_sync_940", sync, 0);
        check("loss_pkt_940", pkt_start, 0);
`ifdef TS_SYNC_ERRCNT_EN
        check("loss_err_940", err_cnt, 3);
`endif
      end
      if (i == 1316) check("loss_sync_1316", sync, 0);
      if (i == 1504) begin
        check("loss_sync_1504", sync, 1);
        check("loss_pkt_1504", pkt_start, 1);
      end
    end

    do_reset();
    for (int i = 0; i < 577; i++) begin
      send((i == 10) ? 8'h47 : ts(i, 200), 1'b1);
      if (i == 575) check("false_no_sync", sync_seen, 0);
      if (i == 576) begin
        check("false_sync_576", sync, 1);
        check("false_pkt_576", pkt_start, 1);
      end
    end

    send(8'hAA, 1'b1);
    check("async_pre_byte", byte_out, 8'hAA);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_sync", sync, 0);
    check("async_valid", valid_out, 0);
    check("async_byte", byte_out, 0);
    check("async_pkt", pkt_start, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 377; i++) begin
      send(ts(i, 0), 1'b1);
      if (i == 188) check("async_relock_188", sync, 0);
      if (i == 376) check("async_relock_376", sync, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
